tpg_monitor: RTL and testbench

TPG_MONITOR -- requirements
Module: tpg_monitor

---
 rtl/tpg_monitor.sv | 145 ++++++++++++++
 tb/tb_tpg_monitor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tpg_monitor.sv
// Measures incoming test-pattern video: active width/height, frame count and per-frame integrity flags.
// Results are published one cycle after each frame-closing vs rise; input only, no backpressure.
module tpg_monitor #(
    parameter int PW     = 8,
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                hs,
    input  logic                vs,
    input  logic                vld,
    input  logic [3*PW-1:0]     rgb,
    output logic                locked,
    output logic [H_BITS-1:0]   act_width,
    output logic [V_BITS-1:0]   act_height,
    output logic [15:0]         frame_cnt,
    output logic                meas_vld,
    output logic                width_err,
    output logic                chan_err,
    output logic                seq_err
);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t state, stateNext;

    logic              unusedHsD;
    logic              vsD, vldD;
    logic [H_BITS-1:0] pxCnt, refW;
    logic [V_BITS-1:0] lineCnt;
    logic              wErr, cErr, sErr;
    logic [PW-1:0]     prevR;
    logic              seedVld;

    logic              vsRise, inFrame, closeLine, pixelAct, firstLine;
    logic [PW-1:0]     rCur, gCur, bCur, rExpect;
    logic [H_BITS-1:0] pxInc, refClosed;
    logic [V_BITS-1:0] lineClosed;
    logic              wErrClosed, pxChanErr, pxSeqErr;

    assign rCur = rgb[3*PW-1 -: PW];
    assign gCur = rgb[2*PW-1 -: PW];
    assign bCur = rgb[PW-1:0];

    assign vsRise   = vs & ~vsD;
    assign inFrame  = (state == FRAME);
    // A line still open at vs rise is closed into the ending frame, same as a vld fall.
    assign closeLine = inFrame & vldD & (~vld | vsRise);
    // A pixel on the vs rise cycle already belongs to the new frame.
    assign pixelAct  = vld & (inFrame | vsRise);
    assign firstLine = (lineCnt == '0);

    assign pxInc      = (pxCnt == '1) ? pxCnt : pxCnt + H_BITS'(1);
    assign lineClosed = !closeLine ? lineCnt :
                        ((lineCnt == '1) ? lineCnt : lineCnt + V_BITS'(1));
    assign refClosed  = (closeLine & firstLine) ? pxCnt : refW;
    assign wErrClosed = wErr | (closeLine & ~firstLine & (pxCnt != refW));

    assign rExpect   = prevR + PW'(1);
    assign pxChanErr = pixelAct & ((rCur != gCur) | (gCur != bCur));
    assign pxSeqErr  = pixelAct & seedVld & (rCur != rExpect);

    always_comb begin
        stateNext = state;
        if (vsRise) begin
            stateNext = FRAME;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            unusedHsD  <= 1'b0;
            vsD        <= 1'b0;
            vldD       <= 1'b0;
            pxCnt      <= '0;
            refW       <= '0;
            lineCnt    <= '0;
            wErr       <= 1'b0;
            cErr       <= 1'b0;
            sErr       <= 1'b0;
            prevR      <= '0;
            seedVld    <= 1'b0;
            locked     <= 1'b0;
            act_width  <= '0;
            act_height <= '0;
            frame_cnt  <= '0;
            meas_vld   <= 1'b0;
            width_err  <= 1'b0;
            chan_err   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            unusedHsD <= hs;
            vsD       <= vs;
            vldD      <= vld;
            meas_vld  <= 1'b0;

            // The red-ramp seed survives frame boundaries; only reset clears it.
            if (pixelAct) begin
                prevR   <= rCur;
                seedVld <= 1'b1;
            end

            if (inFrame & vsRise) begin
                act_width  <= refClosed;
                act_height <= lineClosed;
                width_err  <= wErrClosed;
                chan_err   <= cErr;
                seq_err    <= sErr;
                frame_cnt  <= frame_cnt + 16'd1;
                meas_vld   <= 1'b1;
            end

            if (vsRise) begin
                locked  <= 1'b1;
                lineCnt <= '0;
                refW    <= '0;
                wErr    <= 1'b0;
                cErr    <= pxChanErr;
                sErr    <= pxSeqErr;
                pxCnt   <= pixelAct ? H_BITS'(1) : '0;
            end else if (inFrame) begin
                lineCnt <= lineClosed;
                refW    <= refClosed;
                wErr    <= wErrClosed;
                cErr    <= cErr | pxChanErr;
                sErr    <= sErr | pxSeqErr;
                if (closeLine) begin
                    pxCnt <= '0;
                end else if (pixelAct) begin
                    pxCnt <= pxInc;
                end
            end
        end
    end

endmodule

// File: tb/tb_tpg_monitor.sv
// Directed bench for tpg_monitor: frame-level model (line-length queue) checked every cycle.
module tb_tpg_monitor;

    logic        clk = 1'b0;
    logic        rst, hs, vs, vld;
    logic [23:0] rgb;
    logic        locked, meas_vld, width_err, chan_err, seq_err;
    logic [11:0] act_width;
    logic [11:0] act_height;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    tpg_monitor dut (
        .clk(clk), .rst(rst), .hs(hs), .vs(vs), .vld(vld), .rgb(rgb),
        .locked(locked), .act_width(act_width), .act_height(act_height),
        .frame_cnt(frame_cnt), .meas_vld(meas_vld), .width_err(width_err),
        .chan_err(chan_err), .seq_err(seq_err)
    );

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    bit cmpEn = 0;

    logic        eLocked = 0, ePulse = 0, eWe = 0, eCe = 0, eSe = 0;
    logic [11:0] eW = 0, eH = 0;
    logic [15:0] eFc = 0;

    int         mLines[$];
    int         mCur = 0;
    bit         mChan = 0, mSeq = 0, mSeeded = 0, mInFrame = 0, lastVs = 0, lastVld = 0;
    logic [7:0] mPrev = 0;
    int         c = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmpEn) begin
            chk("locked", {31'd0, locked}, {31'd0, eLocked});
            chk("meas_vld", {31'd0, meas_vld}, {31'd0, ePulse});
            chk("act_width", {20'd0, act_width}, {20'd0, eW});
            chk("act_height", {20'd0, act_height}, {20'd0, eH});
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, eFc});
            chk("width_err", {31'd0, width_err}, {31'd0, eWe});
            chk("chan_err", {31'd0, chan_err}, {31'd0, eCe});
            chk("seq_err", {31'd0, seq_err}, {31'd0, eSe});
            if (meas_vld === 1'b1) pulses++;
        end
    end

    // Drive one cycle and advance the frame-level model; expectations apply after the edge.
    task automatic step(input bit rs, input bit h, input bit v, input bit d,
                        input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
        bit          rise, nLocked, nPulse, nWe, nCe, nSe;
        logic [11:0] nW, nH;
        logic [15:0] nFc;
        rst = rs; hs = h; vs = v; vld = d; rgb = {rr, gg, bb};
        nLocked = eLocked; nPulse = 0; nWe = eWe; nCe = eCe; nSe = eSe;
        nW = eW; nH = eH; nFc = eFc;
        if (rs) begin
            nLocked = 0; nWe = 0; nCe = 0; nSe = 0; nW = 0; nH = 0; nFc = 0;
            mLines.delete(); mCur = 0; mChan = 0; mSeq = 0; mSeeded = 0;
            mInFrame = 0; lastVs = 0; lastVld = 0;
        end else begin
            rise = v && !lastVs;
            if (mInFrame && lastVld && (!d || rise)) begin
                mLines.push_back(mCur);
                mCur = 0;
            end
            if (rise) begin
                if (mInFrame) begin
                    nPulse = 1;
                    nH = 12'(mLines.size());
                    nW = (mLines.size() > 0) ? 12'(mLines[0]) : 12'd0;
                    nWe = 0;
                    foreach (mLines[i]) if (mLines[i] != mLines[0]) nWe = 1;
                    nCe = mChan; nSe = mSeq;
                    nFc = eFc + 16'd1;
                end
                nLocked = 1; mInFrame = 1;
                mLines.delete(); mCur = 0; mChan = 0; mSeq = 0;
            end
            if (d && mInFrame) begin
                mCur++;
                if (rr != gg || gg != bb) mChan = 1;
                if (mSeeded && rr != 8'(mPrev + 8'd1)) mSeq = 1;
                mPrev = rr; mSeeded = 1;
            end
            lastVs = v; lastVld = d;
        end
        @(posedge clk);
        #1;
        eLocked = nLocked; ePulse = nPulse; eWe = nWe; eCe = nCe; eSe = nSe;
        eW = nW; eH = nH; eFc = nFc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'd0, 8'd0, 8'd0);
    endtask

    // glitch: 1 = one pixel with G=R+1, 2 = one skipped ramp value; coincide: no gap after last line
    task automatic frame(input int nl, input int shortLine, input int glitch, input bit coincide);
        step(0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        step(0, 0, 1, 0, 8'd0, 8'd0, 8'd0);
        idle(2);
        for (int l = 0; l < nl; l++) begin
            int len;
            len = (l == shortLine) ? 14 : 15;
            for (int p = 0; p < len; p++) begin
                logic [7:0] cv, gv;
                if (glitch == 2 && l == 2 && p == 5) c++;
                cv = 8'(c);
                gv = (glitch == 1 && l == 2 && p == 5) ? 8'(cv + 8'd1) : cv;
                step(0, 0, 0, 1, cv, gv, cv);
                c++;
            end
            if (!(coincide && l == nl - 1)) begin
                idle(1);
                step(0, 1, 0, 0, 8'd0, 8'd0, 8'd0);
                idle(1);
            end
        end
    endtask

    initial begin
        int p0;
        rst = 1; hs = 0; vs = 0; vld = 0; rgb = '0;
        step(1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
        cmpEn = 1;
        step(1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        idle(2);

        frame(10, -1, 0, 0);
        frame(10, -1, 0, 0);
        frame(10, -1, 0, 0);
        chk("clean_fc", {16'd0, frame_cnt}, 32'd2);
        chk("clean_width", {20'd0, act_width}, 32'd15);
        chk("clean_height", {20'd0, act_height}, 32'd10);
        chk("wrap_seq_err", {31'd0, seq_err}, 32'd0);
        chk("clean_pulses", pulses, 32'd2);

        frame(10, 3, 0, 0);
        frame(10, -1, 0, 0);
        chk("short_width_err", {31'd0, width_err}, 32'd1);
        chk("short_width", {20'd0, act_width}, 32'd15);
        frame(10, -1, 1, 0);
        chk("recover_width_err", {31'd0, width_err}, 32'd0);
        frame(10, -1, 2, 0);
        chk("chan_err_set", {31'd0, chan_err}, 32'd1);
        chk("chan_no_seq", {31'd0, seq_err}, 32'd0);
        frame(10, -1, 0, 1);
        chk("seq_err_set", {31'd0, seq_err}, 32'd1);
        chk("seq_no_chan", {31'd0, chan_err}, 32'd0);
        frame(5, -1, 0, 0);
        chk("coincide_height", {20'd0, act_height}, 32'd10);
        chk("coincide_fc", {16'd0, frame_cnt}, 32'd8);

        step(1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
        chk("midrst_locked", {31'd0, locked}, 32'd0);
        chk("midrst_width", {20'd0, act_width}, 32'd0);
        chk("midrst_fc", {16'd0, frame_cnt}, 32'd0);
        idle(2);
        p0 = pulses;
        frame(10, -1, 0, 0);
        chk("relock_no_pulse", pulses, p0);
        chk("relock_locked", {31'd0, locked}, 32'd1);
        frame(0, -1, 0, 0);
        chk("after_rst_pulse", pulses, p0 + 1);
        chk("after_rst_height", {20'd0, act_height}, 32'd10);
        chk("after_rst_fc", {16'd0, frame_cnt}, 32'd1);
        frame(0, -1, 0, 0);
        chk("empty_width", {20'd0, act_width}, 32'd0);
        chk("empty_height", {20'd0, act_height}, 32'd0);
        chk("empty_fc", {16'd0, frame_cnt}, 32'd2);
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
